count_one_pipe: RTL and testbench



---
 rtl/count_one_pipe.sv | 160 ++++++++++++++++
 tb/tb_count_one_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/count_one_pipe.sv
// Two-stage pipelined population counter with valid/ready handshake on both sides.
// Stage 1 counts ones per ChunkWidth-bit chunk; stage 2 sums the chunks and keeps a
// per-packet running total delimited by last_i.
// Optional: define COUNT_ONE_ACC_SAT_EN to saturate the accumulator and flag overflow
// on acc_ovf_o; otherwise the accumulator wraps and acc_ovf_o is tied low.
module count_one_pipe #(
  parameter int unsigned InputWidth = 64,
  parameter int unsigned ChunkWidth = 8,
  parameter int unsigned AccWidth   = 16,
  localparam int unsigned CountWidth = $clog2(InputWidth + 1)
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [InputWidth-1:0] bits_i,
  input  logic                  acc_en_i,
  input  logic                  last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CountWidth-1:0] cnt_o,
  output logic [AccWidth-1:0]   acc_o,
  output logic                  last_o,
  output logic                  acc_ovf_o
);

  localparam int unsigned NumChunks     = (InputWidth + ChunkWidth - 1) / ChunkWidth;
  localparam int unsigned PadWidth      = NumChunks * ChunkWidth;
  localparam int unsigned ChunkCntWidth = $clog2(ChunkWidth + 1);

  // Pipeline handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, s2_load;

  assign s2_adv     = !s2_valid_q | out_ready_i;
  assign s1_adv     = !s1_valid_q | s2_adv;
  assign s2_load    = s2_adv & s1_valid_q;
  assign in_ready_o = s1_adv;

  // Stage 1 combinational chunk counts
  logic [PadWidth-1:0]                         bits_pad;
  logic [NumChunks-1:0][ChunkCntWidth-1:0]     chunk_cnt;
  logic [NumChunks-1:0][ChunkCntWidth-1:0]     s1_cnt_q;
  logic                                        s1_acc_en_q, s1_last_q;

  // Popcount of each chunk; the tail beyond InputWidth is zero-padded
  always_comb begin
    bits_pad  = PadWidth'(bits_i);
    chunk_cnt = '0;
    for (int c = 0; c < NumChunks; c++) begin
      for (int b = 0; b < ChunkWidth; b++) begin
        chunk_cnt[c] = chunk_cnt[c] + ChunkCntWidth'(bits_pad[c*ChunkWidth+b]);
      end
    end
  end

  // Stage 1 registers load whenever the stage can advance
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_cnt_q    <= '0;
      s1_acc_en_q <= 1'b0;
      s1_last_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_cnt_q    <= chunk_cnt;
        s1_acc_en_q <= acc_en_i;
        s1_last_q   <= last_i;
      end
    end
  end

  // Stage 2 combinational chunk sum; never exceeds InputWidth so CountWidth suffices
  logic [CountWidth-1:0] beat_sum;

  // Sum of the stage-1 chunk counts
  always_comb begin
    beat_sum = '0;
    for (int c = 0; c < NumChunks; c++) begin
      beat_sum = beat_sum + CountWidth'(s1_cnt_q[c]);
    end
  end

  // Accumulator next state
  logic [AccWidth-1:0] acc_q, acc_d, acc_base;
  logic                clear_pending_q, clear_pending_d;
  logic [CountWidth-1:0] cnt_q;
  logic                last_q;

`ifdef COUNT_ONE_ACC_SAT_EN
  logic              ovf_q, ovf_d;
  logic [AccWidth:0] acc_wide;

  // Saturating accumulate; overflow is sticky until the packet ends
  always_comb begin
    acc_base        = clear_pending_q ? '0 : acc_q;
    acc_wide        = {1'b0, acc_base} + (AccWidth + 1)'(beat_sum);
    acc_d           = AccWidth'(beat_sum);
    clear_pending_d = 1'b1;
    ovf_d           = 1'b0;
    if (s1_acc_en_q) begin
      acc_d           = acc_wide[AccWidth] ? '1 : acc_wide[AccWidth-1:0];
      clear_pending_d = s1_last_q;
      ovf_d           = (ovf_q & !clear_pending_q) | acc_wide[AccWidth];
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (s2_load) begin
      ovf_q <= ovf_d;
    end
  end

  assign acc_ovf_o = ovf_q;
`else
  // Wrapping accumulate
  always_comb begin
    acc_base        = clear_pending_q ? '0 : acc_q;
    acc_d           = AccWidth'(beat_sum);
    clear_pending_d = 1'b1;
    if (s1_acc_en_q) begin
      acc_d           = acc_base + AccWidth'(beat_sum);
      clear_pending_d = s1_last_q;
    end
  end

  assign acc_ovf_o = 1'b0;
`endif

  // Stage 2 registers; they hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q      <= 1'b0;
      cnt_q           <= '0;
      acc_q           <= '0;
      last_q          <= 1'b0;
      clear_pending_q <= 1'b1;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        cnt_q           <= beat_sum;
        acc_q           <= acc_d;
        last_q          <= s1_last_q;
        clear_pending_q <= clear_pending_d;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign cnt_o       = cnt_q;
  assign acc_o       = acc_q;
  assign last_o      = last_q;

endmodule

// File: tb/tb_count_one_pipe.sv
// Directed bench for count_one_pipe: a default-width instance plus an AccWidth=8
// instance sharing the same stimulus. Expectations for the narrow accumulator follow
// COUNT_ONE_ACC_SAT_EN.
module tb_count_one_pipe;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid, acc_en, last, out_ready;
  logic [63:0] bits;

  logic        in_ready, out_valid, last_o, ovf;
  logic [6:0]  cnt;
  logic [15:0] acc;
  logic        in_ready8, out_valid8, last8, ovf8;
  logic [6:0]  cnt8;
  logic [7:0]  acc8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  count_one_pipe dut (
    .clk(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .bits_i(bits), .acc_en_i(acc_en), .last_i(last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .cnt_o(cnt), .acc_o(acc), .last_o(last_o), .acc_ovf_o(ovf)
  );

  count_one_pipe #(.AccWidth(8)) dut8 (
    .clk(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(in_ready8),
    .bits_i(bits), .acc_en_i(acc_en), .last_i(last), .out_valid_o(out_valid8),
    .out_ready_i(out_ready), .cnt_o(cnt8), .acc_o(acc8), .last_o(last8), .acc_ovf_o(ovf8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Stream description, filled per test
  logic [63:0] s_bits [8];
  logic        s_en   [8];
  logic        s_last [8];
  int          e_cnt  [8];
  int          e_acc  [8];
  logic        e_last [8];
  logic        e_ovf  [8];

  // Back-to-back beats with out_ready high; result i is due two cycles after its drive
  task automatic run_stream(input int n, input bit narrow);
    int j;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i < n) begin
        in_valid = 1'b1; bits = s_bits[i]; acc_en = s_en[i]; last = s_last[i];
      end else begin
        in_valid = 1'b0; bits = '0; acc_en = 1'b0; last = 1'b0;
      end
      #1;
      if (i < n) check_eq("in_ready", 64'(in_ready), 64'(1));
      if (i < 2) begin
        check_eq("valid_early", 64'(narrow ? out_valid8 : out_valid), 64'(0));
      end else begin
        j = i - 2;
        check_eq("valid", 64'(narrow ? out_valid8 : out_valid), 64'(1));
        check_eq("cnt", 64'(narrow ? cnt8 : cnt), 64'(e_cnt[j]));
        check_eq("acc", narrow ? 64'(acc8) : 64'(acc), 64'(e_acc[j]));
        check_eq("last", 64'(narrow ? last8 : last_o), 64'(e_last[j]));
        check_eq("ovf", 64'(narrow ? ovf8 : ovf), 64'(e_ovf[j]));
      end
    end
    @(negedge clk);
    #1;
    check_eq("valid_drained", 64'(narrow ? out_valid8 : out_valid), 64'(0));
  endtask

  initial begin
    int tx, rx, first_c, last_c;
    logic [63:0] ones;

    rst_ni = 1'b0; in_valid = 1'b0; bits = '0; acc_en = 1'b0; last = 1'b0;
    out_ready = 1'b1;
    #12;
    // Reset state
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_cnt", 64'(cnt), 64'(0));
    check_eq("rst_acc", 64'(acc), 64'(0));
    check_eq("rst_last", 64'(last_o), 64'(0));
    check_eq("rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;

    // Single beat, non-accumulating
    s_bits[0] = 64'hFF00_0000_0000_0001; s_en[0] = 1'b0; s_last[0] = 1'b0;
    e_cnt[0] = 9; e_acc[0] = 9; e_last[0] = 1'b0; e_ovf[0] = 1'b0;
    run_stream(1, 1'b0);

    // All-ones then all-zeros, back to back
    s_bits[0] = '1; s_en[0] = 1'b0; s_last[0] = 1'b0;
    s_bits[1] = '0; s_en[1] = 1'b0; s_last[1] = 1'b0;
    e_cnt[0] = 64; e_acc[0] = 64; e_last[0] = 1'b0; e_ovf[0] = 1'b0;
    e_cnt[1] = 0;  e_acc[1] = 0;  e_last[1] = 1'b0; e_ovf[1] = 1'b0;
    run_stream(2, 1'b0);

    // Back-pressure: counts 1..6, consumer stalled for the first 5 cycles
    tx = 0; rx = 0; first_c = -1; last_c = -1;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (tx < 6) begin
        ones = (64'(1) << (tx + 1)) - 64'(1);
        in_valid = 1'b1; bits = ones; acc_en = 1'b0; last = 1'b0;
      end else begin
        in_valid = 1'b0; bits = '0;
      end
      #1;
      if (cyc == 0) check_eq("bp_ready_start", 64'(in_ready), 64'(1));
      if (cyc == 2) check_eq("bp_ready_drop", 64'(in_ready), 64'(0));
      if (out_valid) begin
        check_eq("bp_cnt", 64'(cnt), 64'(rx + 1));
        if (out_ready) begin
          if (rx == 0) first_c = cyc;
          last_c = cyc;
          rx++;
        end
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("bp_drained", 64'(rx), 64'(6));
    check_eq("bp_no_gaps", 64'(last_c - first_c), 64'(5));

    // Accumulate counts 3, 5, 64 (last), then 1 starting a new packet
    s_bits[0] = 64'h7;  s_en[0] = 1'b1; s_last[0] = 1'b0;
    s_bits[1] = 64'h1F; s_en[1] = 1'b1; s_last[1] = 1'b0;
    s_bits[2] = '1;     s_en[2] = 1'b1; s_last[2] = 1'b1;
    s_bits[3] = 64'h1;  s_en[3] = 1'b1; s_last[3] = 1'b0;
    e_cnt[0] = 3;  e_acc[0] = 3;  e_last[0] = 1'b0; e_ovf[0] = 1'b0;
    e_cnt[1] = 5;  e_acc[1] = 8;  e_last[1] = 1'b0; e_ovf[1] = 1'b0;
    e_cnt[2] = 64; e_acc[2] = 72; e_last[2] = 1'b1; e_ovf[2] = 1'b0;
    e_cnt[3] = 1;  e_acc[3] = 1;  e_last[3] = 1'b0; e_ovf[3] = 1'b0;
    run_stream(4, 1'b0);

    // Reset with two beats in flight (open packet continues: 1 + 3 = 4)
    @(negedge clk);
    in_valid = 1'b1; bits = 64'h7; acc_en = 1'b1; last = 1'b0;
    @(negedge clk);
    bits = 64'h3;
    @(negedge clk);
    in_valid = 1'b0; bits = '0; acc_en = 1'b0;
    #1;
    check_eq("mid_pre_valid", 64'(out_valid), 64'(1));
    check_eq("mid_pre_acc", 64'(acc), 64'(4));
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst_acc", 64'(acc), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_still_idle", 64'(out_valid), 64'(0));
    s_bits[0] = 64'hF; s_en[0] = 1'b1; s_last[0] = 1'b1;
    e_cnt[0] = 4; e_acc[0] = 4; e_last[0] = 1'b1; e_ovf[0] = 1'b0;
    run_stream(1, 1'b0);

    // AccWidth=8: five all-ones beats (last on fifth), then one new-packet beat
    for (int i = 0; i < 5; i++) begin
      s_bits[i] = '1; s_en[i] = 1'b1; s_last[i] = (i == 4); e_cnt[i] = 64; e_last[i] = (i == 4);
    end
    s_bits[5] = 64'h1; s_en[5] = 1'b1; s_last[5] = 1'b1;
    e_cnt[5] = 1; e_acc[5] = 1; e_last[5] = 1'b1; e_ovf[5] = 1'b0;
    e_acc[0] = 64; e_acc[1] = 128; e_acc[2] = 192;
    e_ovf[0] = 1'b0; e_ovf[1] = 1'b0; e_ovf[2] = 1'b0;
`ifdef COUNT_ONE_ACC_SAT_EN
    e_acc[3] = 255; e_acc[4] = 255; e_ovf[3] = 1'b1; e_ovf[4] = 1'b1;
`else
    e_acc[3] = 0;   e_acc[4] = 64;  e_ovf[3] = 1'b0; e_ovf[4] = 1'b0;
`endif
    run_stream(6, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung handshake
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
